// File: rtl/alu_exec_stage.sv
// Execute-stage ALU: single-cycle add/sub/logic, iterative 1-bit-per-cycle shifts,
// valid/ready handshakes on both sides with registered result, zero and overflow.
module alu_exec_stage #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       opcode,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic [4:0]       shamt,
    input  logic             set_lt,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             overflow
);

    localparam int unsigned SHW = 5;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_ADDU = 4'd1;
    localparam logic [3:0] OP_SUB  = 4'd2;
    localparam logic [3:0] OP_SUBU = 4'd3;
    localparam logic [3:0] OP_AND  = 4'd4;
    localparam logic [3:0] OP_OR   = 4'd5;
    localparam logic [3:0] OP_XOR  = 4'd6;
    localparam logic [3:0] OP_LSL  = 4'd7;
    localparam logic [3:0] OP_LSR  = 4'd8;
    localparam logic [3:0] OP_ASR  = 4'd9;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] shreg;
    logic [SHW-1:0]   cnt;
    logic [3:0]       sh_op;

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   diff;
    logic             ovf_add;
    logic             ovf_sub;
    logic             is_shift;
    logic [WIDTH-1:0] alu_res;
    logic             alu_ovf;
    logic [WIDTH-1:0] shift_next;

    // Ready is purely a state decode, masked while reset is held
    assign in_ready = (state == IDLE) && rst_n;

    // Single-cycle datapath evaluated on the live operands at the accept edge
    always_comb begin
        sum      = {1'b0, op_a} + {1'b0, op_b};
        diff     = {1'b0, op_a} - {1'b0, op_b};
        ovf_add  = (op_a[WIDTH-1] == op_b[WIDTH-1]) && (sum[WIDTH-1] != op_a[WIDTH-1]);
        ovf_sub  = (op_a[WIDTH-1] != op_b[WIDTH-1]) && (diff[WIDTH-1] != op_a[WIDTH-1]);
        is_shift = (opcode == OP_LSL) || (opcode == OP_LSR) || (opcode == OP_ASR);
        alu_res  = '0;
        alu_ovf  = 1'b0;
        case (opcode)
            OP_ADD: begin
                alu_res = sum[WIDTH-1:0];
                alu_ovf = ovf_add;
            end
            OP_ADDU: alu_res = sum[WIDTH-1:0];
            OP_SUB: begin
                if (set_lt) begin
                    alu_res = WIDTH'(diff[WIDTH-1] ^ ovf_sub);
                end else begin
                    alu_res = diff[WIDTH-1:0];
                    alu_ovf = ovf_sub;
                end
            end
            OP_SUBU: alu_res = set_lt ? WIDTH'(diff[WIDTH]) : diff[WIDTH-1:0];
            OP_AND:  alu_res = op_a & op_b;
            OP_OR:   alu_res = op_a | op_b;
            OP_XOR:  alu_res = op_a ^ op_b;
            OP_LSL, OP_LSR, OP_ASR: alu_res = op_b;
            default: alu_res = '0;
        endcase
    end

    // One-bit step of the iterative shifter
    always_comb begin
        shift_next = shreg;
        case (sh_op)
            OP_LSL:  shift_next = {shreg[WIDTH-2:0], 1'b0};
            OP_LSR:  shift_next = {1'b0, shreg[WIDTH-1:1]};
            OP_ASR:  shift_next = {shreg[WIDTH-1], shreg[WIDTH-1:1]};
            default: shift_next = shreg;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            shreg     <= '0;
            cnt       <= '0;
            sh_op     <= OP_ADD;
            out_valid <= 1'b0;
            result    <= '0;
            zero      <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        if (is_shift && (shamt != '0)) begin
                            shreg <= op_b;
                            cnt   <= shamt;
                            sh_op <= opcode;
                            state <= SHIFT;
                        end else begin
                            result    <= alu_res;
                            zero      <= (alu_res == '0);
                            overflow  <= alu_ovf;
                            out_valid <= 1'b1;
                            state     <= DONE;
                        end
                    end
                end
                SHIFT: begin
                    shreg <= shift_next;
                    cnt   <= cnt - SHW'(1);
                    if (cnt == SHW'(1)) begin
                        result    <= shift_next;
                        zero      <= (shift_next == '0);
                        overflow  <= 1'b0;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_exec_stage.sv
// Directed, table-driven bench for alu_exec_stage plus hand sequences for
// backpressure and reset during an in-flight shift.
module tb_alu_exec_stage;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_ADDU = 4'd1;
    localparam logic [3:0] OP_SUB  = 4'd2;
    localparam logic [3:0] OP_SUBU = 4'd3;
    localparam logic [3:0] OP_AND  = 4'd4;
    localparam logic [3:0] OP_OR   = 4'd5;
    localparam logic [3:0] OP_XOR  = 4'd6;
    localparam logic [3:0] OP_LSL  = 4'd7;
    localparam logic [3:0] OP_LSR  = 4'd8;
    localparam logic [3:0] OP_ASR  = 4'd9;
    localparam logic [3:0] OP_BAD  = 4'd15;
    localparam int         NVEC    = 18;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  opcode;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [4:0]  shamt;
    logic        set_lt;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        zero;
    logic        overflow;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  sh;
        logic        slt;
        logic [31:0] res;
        logic        z;
        logic        ovf;
        int          lat;
    } vec_t;

    vec_t vecs [NVEC];

    alu_exec_stage #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .opcode    (opcode),
        .op_a      (op_a),
        .op_b      (op_b),
        .shamt     (shamt),
        .set_lt    (set_lt),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Issue one op, measure latency, check outputs, then complete the handshake
    task automatic run_vec(input vec_t v, input string nm);
        int lat;
        @(negedge clk);
        opcode    = v.op;
        op_a      = v.a;
        op_b      = v.b;
        shamt     = v.sh;
        set_lt    = v.slt;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        chk({nm, " in_ready"}, 32'(in_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        opcode   = 4'hE;
        op_a     = ~v.a;
        op_b     = ~v.b;
        shamt    = ~v.sh;
        set_lt   = ~v.slt;
        lat = 1;
        while (!out_valid && lat < 64) begin
            @(negedge clk);
            lat++;
        end
        chk({nm, " latency"}, 32'(lat), 32'(v.lat));
        chk({nm, " result"}, result, v.res);
        chk({nm, " zero"}, 32'(zero), 32'(v.z));
        chk({nm, " overflow"}, 32'(overflow), 32'(v.ovf));
        chk({nm, " in_ready busy"}, 32'(in_ready), 32'd0);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk({nm, " out_valid drop"}, 32'(out_valid), 32'd0);
        chk({nm, " in_ready idle"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] held_res;
        logic        held_z;
        logic        held_o;
        int          seen;

        vecs[0]  = '{OP_ADD,  32'h7FFFFFFF, 32'h00000001, 5'd0,  1'b0, 32'h80000000, 1'b0, 1'b1, 1};
        vecs[1]  = '{OP_SUBU, 32'h00000001, 32'hFFFFFFFF, 5'd0,  1'b1, 32'h00000001, 1'b0, 1'b0, 1};
        vecs[2]  = '{OP_SUB,  32'h00000001, 32'hFFFFFFFF, 5'd0,  1'b1, 32'h00000000, 1'b1, 1'b0, 1};
        vecs[3]  = '{OP_ASR,  32'h0,        32'h80000000, 5'd4,  1'b0, 32'hF8000000, 1'b0, 1'b0, 5};
        vecs[4]  = '{OP_LSL,  32'h0,        32'h00001234, 5'd0,  1'b0, 32'h00001234, 1'b0, 1'b0, 1};
        vecs[5]  = '{OP_AND,  32'hF0F0F0F0, 32'hFF00FF00, 5'd0,  1'b0, 32'hF000F000, 1'b0, 1'b0, 1};
        vecs[6]  = '{OP_OR,   32'h0F0F0000, 32'h000000F0, 5'd0,  1'b0, 32'h0F0F00F0, 1'b0, 1'b0, 1};
        vecs[7]  = '{OP_XOR,  32'hFFFF0000, 32'hFFFFFFFF, 5'd0,  1'b0, 32'h0000FFFF, 1'b0, 1'b0, 1};
        vecs[8]  = '{OP_SUB,  32'h80000000, 32'h00000001, 5'd0,  1'b0, 32'h7FFFFFFF, 1'b0, 1'b1, 1};
        vecs[9]  = '{OP_SUBU, 32'h00000000, 32'h00000001, 5'd0,  1'b0, 32'hFFFFFFFF, 1'b0, 1'b0, 1};
        vecs[10] = '{OP_ADDU, 32'hFFFFFFFF, 32'h00000001, 5'd0,  1'b0, 32'h00000000, 1'b1, 1'b0, 1};
        vecs[11] = '{OP_LSR,  32'h0,        32'h80000001, 5'd1,  1'b0, 32'h40000000, 1'b0, 1'b0, 2};
        vecs[12] = '{OP_LSL,  32'h0,        32'h00000001, 5'd31, 1'b0, 32'h80000000, 1'b0, 1'b0, 32};
        vecs[13] = '{OP_ASR,  32'h0,        32'h7FFFFFFF, 5'd31, 1'b0, 32'h00000000, 1'b1, 1'b0, 32};
        vecs[14] = '{OP_BAD,  32'hFFFFFFFF, 32'hFFFFFFFF, 5'd0,  1'b0, 32'h00000000, 1'b1, 1'b0, 1};
        vecs[15] = '{OP_ADD,  32'h00000005, 32'h00000003, 5'd0,  1'b1, 32'h00000008, 1'b0, 1'b0, 1};
        vecs[16] = '{OP_SUB,  32'hFFFFFFFB, 32'h00000003, 5'd0,  1'b1, 32'h00000001, 1'b0, 1'b0, 1};
        vecs[17] = '{OP_SUB,  32'h80000000, 32'h00000001, 5'd0,  1'b1, 32'h00000001, 1'b0, 1'b0, 1};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        opcode    = OP_ADD;
        op_a      = '0;
        op_b      = '0;
        shamt     = '0;
        set_lt    = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset in_ready", 32'(in_ready), 32'd0);
        chk("reset out_valid", 32'(out_valid), 32'd0);
        chk("reset result", result, 32'd0);
        chk("reset zero", 32'(zero), 32'd0);
        chk("reset overflow", 32'(overflow), 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < NVEC; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
        end

        // Unknown opcode must never leave X on any output
        run_vec(vecs[14], "bad_op");
        chk("bad_op no X", 32'($isunknown({in_ready, out_valid, result, zero, overflow})), 32'd0);

        // Backpressure: hold results in DONE and refuse new ops
        @(negedge clk);
        opcode   = OP_ADD;
        op_a     = 32'h7FFFFFFF;
        op_b     = 32'h00000001;
        set_lt   = 1'b0;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        opcode = OP_XOR;
        op_a   = 32'h12345678;
        op_b   = 32'h0;
        held_res = 32'h80000000;
        held_z   = 1'b0;
        held_o   = 1'b1;
        for (int c = 0; c < 3; c++) begin
            in_valid = (c != 1);
            @(negedge clk);
            chk("bp out_valid", 32'(out_valid), 32'd1);
            chk("bp result", result, held_res);
            chk("bp zero", 32'(zero), 32'(held_z));
            chk("bp overflow", 32'(overflow), 32'(held_o));
            chk("bp in_ready", 32'(in_ready), 32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("bp release out_valid", 32'(out_valid), 32'd0);
        chk("bp release in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        chk("bp no stray accept", 32'(out_valid), 32'd0);

        // Reset in the middle of a long shift drops the pending op
        opcode   = OP_LSR;
        op_b     = 32'hFFFFFFFF;
        shamt    = 5'd31;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (9) @(negedge clk);
        chk("midshift in_ready", 32'(in_ready), 32'd0);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("midshift reset in_ready", 32'(in_ready), 32'd0);
        chk("midshift reset out_valid", 32'(out_valid), 32'd0);
        rst_n = 1'b1;
        out_ready = 1'b1;
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        out_ready = 1'b0;
        chk("midshift aborted", 32'(seen), 32'd0);
        run_vec(vecs[5], "after_reset_and");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
